// File: rtl/nibble_regbank.sv
// Nibble-wide register bank: program counter with return stack, jump register,
// output register and a synchronised input register behind a load mux.
module nibble_regbank #(
  parameter int NW = 4,
  parameter int NJ = 2,
  parameter int NO = 2,
  parameter int NI = 2,
  parameter int SD = 4,
  localparam int AW = NW * NJ,
  localparam int SW = $clog2(NJ + NI + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             pc_inc,
  input  logic             pc_ld,
  input  logic             pc_call,
  input  logic             pc_ret,
  input  logic [NJ-1:0]    jr_st,
  input  logic [NO-1:0]    or_st,
  input  logic [SW-1:0]    ld_sel,
  input  logic [NW-1:0]    STOREBUS,
  input  logic [NW*NI-1:0] IR,
  output logic [NW-1:0]    LOADBUS,
  output logic [AW-1:0]    PA,
  output logic [NW*NO-1:0] OR,
  output logic             sp_empty,
  output logic             sp_full,
  output logic [2:0]       err
);

  localparam int PW = $clog2(SD + 1);
  localparam logic [PW-1:0] SP_MAX = PW'(SD);
  localparam logic [SW-1:0] SEL_MAX = SW'(NJ + NI);

  logic [AW-1:0]    pc;
  logic [AW-1:0]    jr;
  logic [AW-1:0]    pc_next;
  logic [AW-1:0]    stack_top;
  logic [NW*NO-1:0] or_q;
  logic [NW*NI-1:0] ir_meta;
  logic [NW*NI-1:0] ir_sync;
  logic [PW-1:0]    sp;
  logic [AW-1:0]    stack [SD];
  logic [2:0]       err_q;
  logic             conflict;
  logic             bad_sel;

  assign pc_next  = pc + AW'(1);
  assign conflict = (pc_ret & (pc_call | pc_ld | pc_inc)) |
                    (pc_call & (pc_ld | pc_inc)) |
                    (pc_ld & pc_inc);
  assign bad_sel  = ld_sel > SEL_MAX;
  assign sp_empty = (sp == '0);
  assign sp_full  = (sp == SP_MAX);
  assign PA       = pc;
  assign OR       = or_q;
  assign err      = err_q;

  // Entry below the stack pointer, picked without indexing by an out-of-range sp.
  always_comb begin
    stack_top = '0;
    for (int i = 0; i < SD; i++) begin
      if (sp == PW'(i + 1)) stack_top = stack[i];
    end
  end

  always_comb begin
    LOADBUS = '0;
    for (int k = 0; k < NJ; k++) begin
      if (ld_sel == SW'(k + 1)) LOADBUS = jr[k*NW +: NW];
    end
    for (int k = 0; k < NI; k++) begin
      if (ld_sel == SW'(NJ + 1 + k)) LOADBUS = ir_sync[k*NW +: NW];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc      <= '0;
      jr      <= '0;
      or_q    <= '0;
      ir_meta <= '0;
      ir_sync <= '0;
      sp      <= '0;
      err_q   <= '0;
      for (int i = 0; i < SD; i++) stack[i] <= '0;
    end else begin
      ir_meta <= IR;
      ir_sync <= ir_meta;

      for (int k = 0; k < NJ; k++) begin
        if (jr_st[k]) jr[k*NW +: NW] <= STOREBUS;
      end
      for (int k = 0; k < NO; k++) begin
        if (or_st[k]) or_q[k*NW +: NW] <= STOREBUS;
      end

      // Only the highest-priority control executes; jr here is the pre-edge value.
      if (pc_ret) begin
        if (sp_empty) begin
          err_q[1] <= 1'b1;
        end else begin
          pc <= stack_top;
          sp <= sp - PW'(1);
        end
      end else if (pc_call) begin
        pc <= jr;
        if (sp_full) begin
          err_q[0] <= 1'b1;
        end else begin
          for (int i = 0; i < SD; i++) begin
            if (sp == PW'(i)) stack[i] <= pc_next;
          end
          sp <= sp + PW'(1);
        end
      end else if (pc_ld) begin
        pc <= jr;
      end else if (pc_inc) begin
        pc <= pc_next;
      end

      if (conflict || bad_sel) err_q[2] <= 1'b1;
    end
  end

endmodule
